// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the two-state FSM encoding.
package serial_subtractor_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand bus
// between a controller and the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: D = A - B - Bin,
// Bout set when the bit borrows from the next place.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic w_x;

  assign w_x  = A ^ B;
  assign D    = w_x ^ Bin;
  assign Bout = (~A & B) | (~w_x & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock.
// Diff/Bout only change on the done cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
  logic             r_bout;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bor;
  logic             w_last;
  logic [WIDTH-1:0] w_res;

  full_subtractor u_fs (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_bor),
    .D    (w_d),
    .Bout (w_bor)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB so the LSB lands at bit 0 last
  assign w_res = (r_res >> 1)
               | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_bor   <= 1'b0;
      r_bout  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_bor   <= bus.Bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bor <= w_bor;
          r_res <= w_res;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff  <= w_res;
            r_bout  <= w_bor;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.Diff = r_diff;
  assign bus.Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH 8 and 1)
// and its full_subtractor cell.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic fa, fb, fbin, fd, fbo;

  full_subtractor u_fs (
    .A    (fa),
    .B    (fb),
    .Bin  (fbin),
    .D    (fd),
    .Bout (fbo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h",
               tag, got, exp);
    end
  endtask

  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    input  bit           ign,
    output logic [W:0]   res,
    output int           lat,
    output int           bcnt,
    output int           drift
  );
    logic [W:0] prev;
    @(negedge clk);
    prev      = {bus.Bout, bus.Diff};
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    @(posedge clk);
    lat   = -1;
    bcnt  = 0;
    drift = 0;
    res   = '0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      bus.start = ign && (j == 3 || j == 5);
      if (ign) begin
        bus.A   = ~a;
        bus.B   = a;
        bus.Bin = ~bin;
      end
      if (bus.done) begin
        lat = j;
        res = {bus.Bout, bus.Diff};
        break;
      end
      if (bus.busy) bcnt++;
      if ({bus.Bout, bus.Diff} !== prev) drift++;
    end
    bus.start = 1'b0;
  endtask

  // {A,B,Bin} -> {D,Bout}, worked by hand
  logic [1:0] fs_tab [8] = '{
    2'b00, 2'b11, 2'b11, 2'b01,
    2'b10, 2'b00, 2'b00, 2'b11
  };

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs [5] = '{
    '{8'h05, 8'h03, 1'b0, 9'h002},
    '{8'h03, 8'h05, 1'b0, 9'h1FE},
    '{8'h00, 8'h00, 1'b1, 9'h1FF},
    '{8'hFF, 8'h00, 1'b0, 9'h0FF},
    '{8'h00, 8'hFF, 1'b1, 9'h100}
  };

  initial begin
    logic [W:0] res, exp, hold;
    logic [2:0] idx;
    int lat, bcnt, drift, seen;
    int got, cyc, last;

    bus.start  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus.Bin    = 1'b0;
    bus1.start = 1'b0;
    bus1.A     = '0;
    bus1.B     = '0;
    bus1.Bin   = 1'b0;
    rst_n      = 1'b0;

    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {fa, fb, fbin} = idx;
      #1;
      chk($sformatf("fs%0d", i), {fd, fbo}, fs_tab[i]);
    end

    repeat (2) @(negedge clk);
    chk("rst", {bus.busy, bus.done, bus.Bout, bus.Diff}, 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].bin, 1'b0,
             res, lat, bcnt, drift);
      chk($sformatf("res%0d", v), res, vecs[v].exp);
      chk($sformatf("lat%0d", v), lat, 8);
      if (v == 0) begin
        chk("busy", bcnt, 8);
        chk("hold0", drift, 0);
      end
    end

    // 0x5A - 0x3C - 1 = 0x1D, ignored starts use other operands
    run_op(8'h5A, 8'h3C, 1'b1, 1'b1, res, lat, bcnt, drift);
    chk("ignres", res, 9'h01D);
    chk("ignlat", lat, 8);
    chk("ignhold", drift, 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'h11;
    bus.B     = 8'h22;
    bus.Bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort", {bus.busy, bus.Bout, bus.Diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("nodone", seen, 0);

    run_op(8'h80, 8'h01, 1'b0, 1'b0, res, lat, bcnt, drift);
    chk("fresh", res, 9'h07F);
    chk("freshlat", lat, 8);

    @(negedge clk);
    bus1.start = 1'b1;
    bus1.A     = 1'b0;
    bus1.B     = 1'b1;
    bus1.Bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    chk("w1run", {bus1.busy, bus1.done}, 2'b10);
    @(negedge clk);
    chk("w1done",
        {bus1.busy, bus1.done, bus1.Bout, bus1.Diff},
        4'b0111);

    @(negedge clk);
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.Bin   = 1'($urandom);
    bus.start = 1'b1;
    exp   = {1'b0, bus.A} - {1'b0, bus.B} - {{W{1'b0}}, bus.Bin};
    got   = 0;
    cyc   = 0;
    last  = 0;
    drift = 0;
    hold  = '0;
    while (got < 200 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        chk($sformatf("strm%0d", got),
            {bus.Bout, bus.Diff}, exp);
        if (got > 0) chk("gap", cyc - last, 9);
        last    = cyc;
        got++;
        hold    = {bus.Bout, bus.Diff};
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.Bin = 1'($urandom);
        exp = {1'b0, bus.A} - {1'b0, bus.B}
            - {{W{1'b0}}, bus.Bin};
      end else if (got > 0 &&
                   {bus.Bout, bus.Diff} !== hold) begin
        drift++;
      end
    end
    bus.start = 1'b0;
    chk("strmcnt", got, 200);
    chk("strmhold", drift, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing Diff = A - B - Bin, LSB first, one bit per clock.
- Core is a single-bit full-subtractor cell: the inverse-operation counterpart of the lab full adder.
- Used in the FPGA lab datapath where area matters more than latency.
- Driven by a start/busy/done handshake from a controller or testbench.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when idle
- A  input  WIDTH  minuend; captured on accepted start
- B  input  WIDTH  subtrahend; captured on accepted start
- Bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when Diff/Bout update
- Diff  output  WIDTH  difference, held until the next completion
- Bout  output  1  final borrow-out, held with Diff

Behaviour:
- Reset
  - rst_n low asynchronously clears state to IDLE.
  - Reset values: busy=0, done=0, Diff=0, Bout=0; internal shift registers, borrow and counter all 0.
- States
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE to RUN
  - Start sampled high at edge k while in IDLE: capture A, B and Bin into shift registers and the borrow register; clear bit counter; enter RUN.
  - busy goes high after edge k.
- RUN, edges k+1 .. k+WIDTH
  - Per edge, with a = A-reg bit0, b = B-reg bit0, bor = borrow register:
    - d = a^b^bor
    - bor_next = (~a&b) | (~(a^b)&bor)
  - Shift d into the result shift register at the MSB end, shifting right.
  - Shift the operand registers right.
  - Increment the counter; counter width is $clog2(WIDTH+1).
- RUN to IDLE, at edge k+WIDTH (last bit)
  - Load Diff from the completed result register and Bout from bor_next.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
  - Latency from accepted start to done: WIDTH cycles.
- Diff/Bout stability: unchanged from one completion to the next, including throughout RUN. Results are never partially visible.
- start while busy: ignored, with no effect on operands or result.
- Back-to-back: start high during the done cycle is accepted at the next edge, giving a sustained throughput of one result per WIDTH+1 cycles.
- Held start: start held high continuously restarts each time IDLE is reached, capturing A/B at that edge.
- Arithmetic: modulo 2^WIDTH. Bout=1 exactly when A < B + Bin as unsigned values. The result equals {Bout, Diff} = {1'b0, A} - B - Bin taken modulo 2^(WIDTH+1).
- Reset mid-operation: aborts immediately. Diff/Bout return to 0, and no done pulse is generated.
- WIDTH=1: a single RUN cycle; done one cycle after the start edge.

Decomposition:
- Shared package: state encoding (IDLE, RUN) as a typedef; no other constants.
- Sub-module full_subtractor: combinational, with inputs A, B, Bin and outputs D, Bout.
  - Instantiated once in serial_subtractor.
  - Gets its own exhaustive 8-vector bench, mirroring the full-adder bench.
- The serial_subtractor top module owns the FSM, counter, shift registers and output registers.

Test Plan:
- full_subtractor exhaustive: all 8 {A,B,Bin} combinations -> D = A^B^Bin, Bout = (~A&B)|(~(A^B)&Bin); e.g. 0,1,1 -> D=0, Bout=1.
- WIDTH=8, A=0x05, B=0x03, Bin=0, start pulse -> done exactly 8 cycles after the start edge, Diff=0x02, Bout=0; busy high for those 8 cycles.
- A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout=1. Then A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1. Then A=0xFF, B=0x00, Bin=0 -> Diff=0xFF, Bout=0.
- Start pulses at cycles 3 and 5 after an accepted start, with changed A/B -> ignored; the result matches the first operands. Diff keeps its previous value until done.
- rst_n low for one cycle at cycle 4 of RUN -> busy=0, Diff=0, Bout=0 immediately; no done pulse. A fresh start afterwards completes correctly.
- start held high, 200 random A/B/Bin -> one done every 9 cycles; each {Bout,Diff} equals the model value of A-B-Bin; Diff stable between done pulses.
